lnrv_icb_arbiter: RTL and testbench

N-to-1 ICB arbiter that shares one ICB slave (e.g. an lnrv_icb2sram-fronted ILM/DLM, or the system bus port) between P_ICB_COUNT masters. Round-robin arbitration on the command channel, with grant lock while a presented command is stalled. An in-order outstanding-ID FIFO routes each response back to the master that issued the command. It is the mirror of lnrv_icb_demux and uses the same flattened, index-0-in-LSBs bus packing.

---
 rtl/lnrv_icb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_lnrv_icb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lnrv_icb_arbiter.sv
// N-to-1 ICB arbiter: round-robin command grant with stall lock, and an in-order
// outstanding-ID FIFO that steers each slave response back to its issuing master.
module lnrv_icb_arbiter #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ICB_COUNT  = 3,
    parameter int P_OTS_COUNT  = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,

    input  logic [P_ICB_COUNT-1:0]                  mn_icb_cmd_vld,
    output logic [P_ICB_COUNT-1:0]                  mn_icb_cmd_rdy,
    input  logic [P_ICB_COUNT-1:0]                  mn_icb_cmd_write,
    input  logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0]     mn_icb_cmd_addr,
    input  logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]     mn_icb_cmd_wdata,
    input  logic [P_ICB_COUNT*(P_DATA_WIDTH/8)-1:0] mn_icb_cmd_wstrb,

    output logic [P_ICB_COUNT-1:0]                  mn_icb_rsp_vld,
    input  logic [P_ICB_COUNT-1:0]                  mn_icb_rsp_rdy,
    output logic [P_ICB_COUNT*P_DATA_WIDTH-1:0]     mn_icb_rsp_rdata,
    output logic [P_ICB_COUNT-1:0]                  mn_icb_rsp_err,

    output logic                                    s_icb_cmd_vld,
    input  logic                                    s_icb_cmd_rdy,
    output logic                                    s_icb_cmd_write,
    output logic [P_ADDR_WIDTH-1:0]                 s_icb_cmd_addr,
    output logic [P_DATA_WIDTH-1:0]                 s_icb_cmd_wdata,
    output logic [P_DATA_WIDTH/8-1:0]               s_icb_cmd_wstrb,

    input  logic                                    s_icb_rsp_vld,
    output logic                                    s_icb_rsp_rdy,
    input  logic [P_DATA_WIDTH-1:0]                 s_icb_rsp_rdata,
    input  logic                                    s_icb_rsp_err
);

    localparam int SW = P_DATA_WIDTH / 8;
    localparam int IW = (P_ICB_COUNT > 1) ? $clog2(P_ICB_COUNT) : 1;
    localparam int OW = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
    localparam int CW = $clog2(P_OTS_COUNT + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(P_ICB_COUNT - 1);
    localparam logic [OW-1:0] LAST_SLOT = OW'(P_OTS_COUNT - 1);
    localparam logic [CW-1:0] OTS_MAX   = CW'(P_OTS_COUNT);

    // Arbitration state
    logic [IW-1:0] ptr_q, ptr_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_idx_q, lock_idx_d;

    // Outstanding-ID FIFO state
    logic [IW-1:0] ids_q [P_OTS_COUNT];
    logic [IW-1:0] ids_d [P_OTS_COUNT];
    logic [OW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] grant;
    logic [IW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          cmd_hs;
    logic          rsp_hs;

    assign fifo_full  = (cnt_q == OTS_MAX);
    assign fifo_empty = (cnt_q == '0);
    assign head       = ids_q[rd_ptr_q];

    // Round-robin search starting at the pointer; a stalled command keeps its grant.
    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        grant = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < P_ICB_COUNT; k++) begin
            if (!found && mn_icb_cmd_vld[idx]) begin
                found = 1'b1;
                grant = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        if (lock_q) begin
            grant = lock_idx_q;
        end
    end

    always_comb begin
        s_icb_cmd_write = 1'b0;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_wdata = '0;
        s_icb_cmd_wstrb = '0;
        mn_icb_cmd_rdy  = '0;
        for (int i = 0; i < P_ICB_COUNT; i++) begin
            if (grant == IW'(i)) begin
                s_icb_cmd_write   = mn_icb_cmd_write[i];
                s_icb_cmd_addr    = mn_icb_cmd_addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
                s_icb_cmd_wdata   = mn_icb_cmd_wdata[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                s_icb_cmd_wstrb   = mn_icb_cmd_wstrb[i*SW +: SW];
                mn_icb_cmd_rdy[i] = s_icb_cmd_rdy && !fifo_full;
            end
        end
    end

    assign s_icb_cmd_vld = (|mn_icb_cmd_vld) && !fifo_full;
    assign cmd_hs        = s_icb_cmd_vld && s_icb_cmd_rdy;

    // Responses go only to the master at the FIFO head; data and err are broadcast.
    always_comb begin
        mn_icb_rsp_vld = '0;
        for (int i = 0; i < P_ICB_COUNT; i++) begin
            mn_icb_rsp_vld[i] = s_icb_rsp_vld && !fifo_empty && (head == IW'(i));
        end
    end

    assign s_icb_rsp_rdy    = !fifo_empty && mn_icb_rsp_rdy[head];
    assign rsp_hs           = s_icb_rsp_vld && s_icb_rsp_rdy;
    assign mn_icb_rsp_rdata = {P_ICB_COUNT{s_icb_rsp_rdata}};
    assign mn_icb_rsp_err   = {P_ICB_COUNT{s_icb_rsp_err}};

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (cmd_hs) begin
            ptr_d = (grant == LAST_IDX) ? '0 : grant + 1'b1;
        end
        // A locked master that abandons its command releases the lock.
        if (cmd_hs) begin
            lock_d = 1'b0;
        end else if (lock_q && !mn_icb_cmd_vld[lock_idx_q]) begin
            lock_d = 1'b0;
        end else if (s_icb_cmd_vld && !s_icb_cmd_rdy) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
    end

    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (cmd_hs) begin
            ids_d[wr_ptr_q] = grant;
            wr_ptr_d        = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rsp_hs) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({cmd_hs, rsp_hs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < P_OTS_COUNT; i++) begin
                ids_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ids_q      <= ids_d;
        end
    end

endmodule

// File: tb/tb_lnrv_icb_arbiter.sv
// Bench for lnrv_icb_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based reference model of grant, lock and response routing.
module tb_lnrv_icb_arbiter;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int OTS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    mn_icb_cmd_vld, mn_icb_cmd_rdy, mn_icb_cmd_write;
    logic [N*AW-1:0] mn_icb_cmd_addr;
    logic [N*DW-1:0] mn_icb_cmd_wdata;
    logic [N*SW-1:0] mn_icb_cmd_wstrb;
    logic [N-1:0]    mn_icb_rsp_vld, mn_icb_rsp_rdy, mn_icb_rsp_err;
    logic [N*DW-1:0] mn_icb_rsp_rdata;
    logic            s_icb_cmd_vld, s_icb_cmd_rdy, s_icb_cmd_write;
    logic [AW-1:0]   s_icb_cmd_addr;
    logic [DW-1:0]   s_icb_cmd_wdata;
    logic [SW-1:0]   s_icb_cmd_wstrb;
    logic            s_icb_rsp_vld, s_icb_rsp_rdy, s_icb_rsp_err;
    logic [DW-1:0]   s_icb_rsp_rdata;

    lnrv_icb_arbiter #(
        .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_ICB_COUNT(N), .P_OTS_COUNT(OTS)
    ) dut (
        .clk(clk), .reset(reset),
        .mn_icb_cmd_vld(mn_icb_cmd_vld), .mn_icb_cmd_rdy(mn_icb_cmd_rdy),
        .mn_icb_cmd_write(mn_icb_cmd_write), .mn_icb_cmd_addr(mn_icb_cmd_addr),
        .mn_icb_cmd_wdata(mn_icb_cmd_wdata), .mn_icb_cmd_wstrb(mn_icb_cmd_wstrb),
        .mn_icb_rsp_vld(mn_icb_rsp_vld), .mn_icb_rsp_rdy(mn_icb_rsp_rdy),
        .mn_icb_rsp_rdata(mn_icb_rsp_rdata), .mn_icb_rsp_err(mn_icb_rsp_err),
        .s_icb_cmd_vld(s_icb_cmd_vld), .s_icb_cmd_rdy(s_icb_cmd_rdy),
        .s_icb_cmd_write(s_icb_cmd_write), .s_icb_cmd_addr(s_icb_cmd_addr),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wstrb(s_icb_cmd_wstrb),
        .s_icb_rsp_vld(s_icb_rsp_vld), .s_icb_rsp_rdy(s_icb_rsp_rdy),
        .s_icb_rsp_rdata(s_icb_rsp_rdata), .s_icb_rsp_err(s_icb_rsp_err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owners of outstanding commands in issue order, rotating pointer,
    // and the grant held over from a stalled command.
    logic [1:0] exp_q[$];
    int         m_ptr;
    bit         m_lock;
    int         m_lock_idx;

    int         exp_g;
    bit         exp_svld, exp_cmd_hs, exp_rsp_hs, exp_srsp_rdy;
    logic [N-1:0] exp_mrdy, exp_rsp_vld;

    task automatic model_reset();
        exp_q.delete();
        m_ptr      = 0;
        m_lock     = 0;
        m_lock_idx = 0;
    endtask

    task automatic model_eval();
        bit full;
        full = (exp_q.size() >= OTS);
        if (m_lock) begin
            exp_g = m_lock_idx;
        end else begin
            exp_g = m_ptr;
            for (int k = N - 1; k >= 0; k--)
                if (mn_icb_cmd_vld[(m_ptr + k) % N]) exp_g = (m_ptr + k) % N;
        end
        exp_svld = (|mn_icb_cmd_vld) && !full;
        exp_mrdy = '0;
        if (s_icb_cmd_rdy && !full) exp_mrdy[exp_g] = 1'b1;
        exp_cmd_hs   = exp_svld && s_icb_cmd_rdy;
        exp_rsp_vld  = '0;
        exp_srsp_rdy = 0;
        if (exp_q.size() > 0) begin
            exp_srsp_rdy = mn_icb_rsp_rdy[exp_q[0]];
            if (s_icb_rsp_vld) exp_rsp_vld[exp_q[0]] = 1'b1;
        end
        exp_rsp_hs = s_icb_rsp_vld && exp_srsp_rdy;
    endtask

    task automatic model_update();
        if (exp_rsp_hs) void'(exp_q.pop_front());
        if (exp_cmd_hs) begin
            exp_q.push_back(2'(exp_g));
            m_ptr = (exp_g + 1) % N;
        end
        m_lock     = exp_svld && !s_icb_cmd_rdy;
        m_lock_idx = exp_g;
    endtask

    // Compare every DUT output against the model, 1 time unit after inputs change.
    task automatic settle();
        #1;
        model_eval();
        check_eq("s_cmd_vld", s_icb_cmd_vld, exp_svld);
        if (exp_svld) begin
            check_eq("s_cmd_addr", s_icb_cmd_addr, mn_icb_cmd_addr[exp_g*AW +: AW]);
            check_eq("s_cmd_wdata", s_icb_cmd_wdata, mn_icb_cmd_wdata[exp_g*DW +: DW]);
            check_eq("s_cmd_wstrb", s_icb_cmd_wstrb, mn_icb_cmd_wstrb[exp_g*SW +: SW]);
            check_eq("s_cmd_write", s_icb_cmd_write, mn_icb_cmd_write[exp_g]);
        end
        if (|mn_icb_cmd_vld) check_eq("m_cmd_rdy", mn_icb_cmd_rdy, exp_mrdy);
        check_eq("m_rsp_vld", mn_icb_rsp_vld, exp_rsp_vld);
        check_eq("s_rsp_rdy", s_icb_rsp_rdy, exp_srsp_rdy);
        check_eq("m_rsp_rdata", mn_icb_rsp_rdata, {N{s_icb_rsp_rdata}});
        check_eq("m_rsp_err", mn_icb_rsp_err, {N{s_icb_rsp_err}});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_update();
        @(negedge clk);
    endtask

    // Driver tasks
    task automatic set_master(input int i, input logic [AW-1:0] addr);
        mn_icb_cmd_addr[i*AW +: AW]  = addr;
        mn_icb_cmd_wdata[i*DW +: DW] = $urandom();
        mn_icb_cmd_wstrb[i*SW +: SW] = SW'($urandom());
        mn_icb_cmd_write[i]          = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(input logic [N-1:0] vld, input logic cmd_rdy,
                         input logic rsp_vld, input logic [N-1:0] rsp_rdy);
        mn_icb_cmd_vld  = vld;
        s_icb_cmd_rdy   = cmd_rdy;
        s_icb_rsp_vld   = rsp_vld;
        mn_icb_rsp_rdy  = rsp_rdy;
        s_icb_rsp_rdata = $urandom();
        s_icb_rsp_err   = 1'($urandom_range(0, 1));
    endtask

    logic [N-1:0] rot_exp [5] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [N-1:0] drain_exp [5] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    bit pend [N];

    initial begin
        reset = 1'b1;
        model_reset();
        drive('0, 1'b0, 1'b0, '0);
        for (int i = 0; i < N; i++) set_master(i, AW'(32'h1000 + i * 32'h100));
        @(negedge clk);
        settle();
        check_eq("reset_cmd_rdy", mn_icb_cmd_rdy, '0);
        tick();
        reset = 1'b0;

        // Single read from master 0 at 0x20, one-cycle response
        set_master(0, 32'h20);
        mn_icb_cmd_write[0] = 1'b0;
        drive(3'b001, 1'b1, 1'b0, 3'b000);
        settle();
        check_eq("t1_addr", s_icb_cmd_addr, 32'h20);
        tick();
        drive(3'b000, 1'b1, 1'b1, 3'b001);
        settle();
        check_eq("t1_rsp_vld", mn_icb_rsp_vld, 3'b001);
        tick();
        drive(3'b000, 1'b1, 1'b1, 3'b111);
        settle();
        check_eq("t1_drained", mn_icb_rsp_vld, 3'b000);
        tick();

        // All masters requesting: grants rotate from pointer 1
        for (int i = 0; i < N; i++) set_master(i, AW'(32'h1000 + i * 32'h100));
        for (int c = 0; c < 5; c++) begin
            drive(3'b111, 1'b1, 1'b1, 3'b111);
            settle();
            check_eq("t2_rotate", mn_icb_cmd_rdy, rot_exp[c]);
            tick();
        end

        // Lock: master 1 stalled, master 0 arrives while pointer favours it
        for (int c = 0; c < 3; c++) begin
            drive((c == 0) ? 3'b010 : 3'b011, 1'b0, 1'b1, 3'b111);
            settle();
            check_eq("t3_lock_addr", s_icb_cmd_addr, 32'h1100);
            tick();
        end
        drive(3'b011, 1'b1, 1'b1, 3'b111);
        settle();
        check_eq("t3_lock_rel", mn_icb_cmd_rdy, 3'b010);
        tick();
        drive(3'b001, 1'b1, 1'b1, 3'b111);
        settle();
        check_eq("t3_next", mn_icb_cmd_rdy, 3'b001);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(3'b000, 1'b0, 1'b1, 3'b111);
            settle();
            tick();
        end

        // Fill the ID FIFO with 2,0,1,2, then drain in order
        for (int c = 0; c < 4; c++) begin
            drive(3'b001 << ((c + 2) % 3), 1'b1, 1'b0, 3'b111);
            settle();
            tick();
        end
        drive(3'b001, 1'b1, 1'b0, 3'b111);
        settle();
        check_eq("t4_full_vld", s_icb_cmd_vld, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            drive((c < 2) ? 3'b001 : 3'b000, 1'b1, 1'b1, 3'b111);
            settle();
            check_eq("t4_drain", mn_icb_rsp_vld, drain_exp[c]);
            if (c == 0) check_eq("t4_blocked", s_icb_cmd_vld, 1'b0);
            if (c == 1) check_eq("t4_after_pop", mn_icb_cmd_rdy, 3'b001);
            tick();
        end

        // Head master 2 not ready holds the response
        drive(3'b100, 1'b1, 1'b0, 3'b111);
        settle();
        tick();
        drive(3'b000, 1'b1, 1'b1, 3'b011);
        settle();
        check_eq("t5_hold", s_icb_rsp_rdy, 1'b0);
        tick();
        drive(3'b000, 1'b1, 1'b1, 3'b111);
        settle();
        check_eq("t5_pop", s_icb_rsp_rdy, 1'b1);
        tick();

        // Reset with two outstanding and a locked grant
        drive(3'b001, 1'b1, 1'b0, 3'b111);
        settle();
        tick();
        drive(3'b010, 1'b1, 1'b0, 3'b111);
        settle();
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(3'b111, 1'b0, 1'b0, 3'b111);
            settle();
            tick();
        end
        reset = 1'b1;
        model_reset();
        drive(3'b000, 1'b0, 1'b1, 3'b111);
        settle();
        check_eq("t6_rst_rsp", mn_icb_rsp_vld, 3'b000);
        tick();
        reset = 1'b0;
        drive(3'b111, 1'b1, 1'b1, 3'b111);
        settle();
        check_eq("t6_ptr0", mn_icb_cmd_rdy, 3'b001);
        check_eq("t6_empty", s_icb_rsp_rdy, 1'b0);
        tick();

        // Randomized traffic; masters hold a command until the model says it was accepted
        for (int i = 0; i < N; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    set_master(i, $urandom());
                    pend[i] = 1;
                end
                mn_icb_cmd_vld[i] = pend[i];
            end
            s_icb_cmd_rdy   = ($urandom_range(0, 3) != 0);
            s_icb_rsp_vld   = 1'($urandom_range(0, 1));
            mn_icb_rsp_rdy  = N'($urandom());
            s_icb_rsp_rdata = $urandom();
            s_icb_rsp_err   = 1'($urandom_range(0, 1));
            settle();
            if (exp_cmd_hs) pend[exp_g] = 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
